// File: rtl/cla_seq_adder_pkg.sv
// Shared definitions for the sequential CLA adder.
//   SLICE_W   : bits handled per cycle by the single cla_block slice
//   ST_*      : FSM state encodings
//   idx_width : width of the slice index for a given operand width
package cla_seq_adder_pkg;

    localparam int SLICE_W = 8;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // A single-slice build still needs a 1-bit index register.
    function automatic int idx_width(input int width);
        int n;
        n = width / SLICE_W;
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cla_seq_adder_if.sv
// Requester-side bus of the sequential CLA adder.
//   master : requester; drives start/sub/a/b, observes ready/done/result/flags
//   slave  : adder; the reverse
interface cla_seq_adder_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ready;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             cout;
    logic             overflow;

    modport master (
        output start, sub, a, b,
        input  ready, done, result, cout, overflow
    );

    modport slave (
        input  start, sub, a, b,
        output ready, done, result, cout, overflow
    );
endinterface

// File: rtl/cla_seq_adder_cla_block.sv
// 8-bit carry-lookahead slice.
//   a, b, c_in : slice operands and carry-in
//   s          : slice sum
//   p, g       : group propagate / generate, independent of c_in, so the
//                caller closes the slice carry as g | (p & c_in)
module cla_block (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       c_in,
    output logic [7:0] s,
    output logic       p,
    output logic       g
);
    logic [7:0] p_vals;
    logic [7:0] g_vals;

    assign p_vals = a | b;
    assign g_vals = a & b;

    always_comb begin
        logic cy;
        s  = '0;
        cy = c_in;
        for (int i = 0; i < 8; i++) begin
            s[i] = a[i] ^ b[i] ^ cy;
            cy   = g_vals[i] | (p_vals[i] & cy);
        end
    end

    always_comb begin
        logic gg;
        gg = g_vals[0];
        for (int i = 1; i < 8; i++) begin
            gg = g_vals[i] | (p_vals[i] & gg);
        end
        g = gg;
        p = &p_vals;
    end
endmodule

// File: rtl/cla_seq_adder.sv
// Multi-cycle WIDTH-bit add/subtract built around one 8-bit cla_block,
// fed one byte per cycle, LSB first.
//   clock, reset : single clock, synchronous active-high reset
//   bus (slave)  : start/sub/a/b in; ready/done/result/cout/overflow out
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | waiting for start, ready=1
//   RUN     | one byte per cycle through the slice, ready=0
//   DONE    | done=1, ready=1 for one cycle; start here chains into RUN
module cla_seq_adder
    import cla_seq_adder_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic            clock,
    input  logic            reset,
    cla_seq_adder_if.slave  bus
);
    localparam int N     = WIDTH / SLICE_W;
    localparam int IDX_W = idx_width(WIDTH);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);

    logic [1:0]         state;
    logic [IDX_W-1:0]   idx;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_eff_q;
    logic               carry;
    logic [WIDTH-1:0]   result_q;
    logic               cout_q;
    logic               ovf_q;

    logic [SLICE_W-1:0] slice_a;
    logic [SLICE_W-1:0] slice_b;
    logic [SLICE_W-1:0] slice_s;
    logic               grp_p;
    logic               grp_g;
    logic               carry_next;
    logic               accept;

    assign slice_a    = a_q[idx*SLICE_W +: SLICE_W];
    assign slice_b    = b_eff_q[idx*SLICE_W +: SLICE_W];
    assign carry_next = grp_g | (grp_p & carry);
    assign accept     = bus.start && (state != ST_RUN);

    cla_block u_slice (
        .a    (slice_a),
        .b    (slice_b),
        .c_in (carry),
        .s    (slice_s),
        .p    (grp_p),
        .g    (grp_g)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= ST_IDLE;
            idx      <= '0;
            a_q      <= '0;
            b_eff_q  <= '0;
            carry    <= 1'b0;
            result_q <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else if (accept) begin
            // Subtraction is A + ~B + 1: invert B once here, carry-in 1.
            a_q     <= bus.a;
            b_eff_q <= bus.sub ? ~bus.b : bus.b;
            carry   <= bus.sub;
            idx     <= '0;
            state   <= ST_RUN;
        end else begin
            case (state)
                ST_RUN: begin
                    result_q[idx*SLICE_W +: SLICE_W] <= slice_s;
                    carry <= carry_next;
                    idx   <= idx + IDX_W'(1);
                    if (idx == IDX_LAST) begin
                        state  <= ST_DONE;
                        cout_q <= carry_next;
                        // The MSB of the result is being written this same
                        // edge, so take it straight from the slice sum.
                        ovf_q  <= (a_q[WIDTH-1] == b_eff_q[WIDTH-1]) &
                                  (slice_s[SLICE_W-1] != a_q[WIDTH-1]);
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.ready    = (state != ST_RUN);
    assign bus.done     = (state == ST_DONE);
    assign bus.result   = result_q;
    assign bus.cout     = cout_q;
    assign bus.overflow = ovf_q;
endmodule
